spi_frame_master: RTL and testbench
===================================

Name: spi_frame_master

Overview:
- SPI master (mode 0, MSB first) that drives SCK/SSEL/MOSI and samples MISO.
- Sends a frame of FRAME_BYTES bytes pulled from a valid/ready byte stream, and returns each full-duplex received byte on a one-cycle strobe.
- Sits on the host/test side of the board-level SPI link and feeds the compressive-sensing slave its 64-byte frames.
- It also reads back the slave's response bytes during a second frame.

Parameters:
FRAME_BYTES, 64, bytes per SSEL-low frame (>=1)
CLK_DIV, 4, clk cycles per SCK half-period (>=4)
GAP_CYCLES, 2, clk cycles of SSEL setup before first SCK edge and hold after last SCK edge (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to run one frame; sampled only in IDLE
tx_data  input  8  next byte to transmit
tx_valid  input  1  tx_data valid
tx_ready  output  1  byte accepted when tx_valid & tx_ready
rx_data  output  8  last received byte, held until next rx_valid
rx_valid  output  1  one-cycle strobe, rx_data new
busy  output  1  high from start acceptance until done
done  output  1  one-cycle pulse at frame end
SCK  output  1  SPI clock, idle low
MOSI  output  1  SPI data out
MISO  input  1  SPI data in, asynchronous to clk
SSEL  output  1  SPI select, active low

Behaviour:
- Reset (async assert, sync deassert via clk):
  - SSEL=1, SCK=0, MOSI=0, tx_ready=0, rx_valid=0, rx_data=0, busy=0, done=0.
  - Counters and FSM go to IDLE.
  - Asserting reset mid-frame aborts immediately: no rx_valid, no done.
- MISO passes through a 2-flop synchronizer; only the synchronized value is used.
- FSM states: IDLE, SETUP, LOAD, SHIFT, HOLD.
- IDLE:
  - SSEL=1, SCK=0.
  - start=1 -> SETUP: SSEL=0 and busy=1 from the next cycle; byte counter cleared.
- SETUP:
  - Wait GAP_CYCLES cycles, then -> LOAD.
- LOAD:
  - tx_ready=1, SCK=0.
  - On tx_valid & tx_ready: shift register <= tx_data, MOSI <= tx_data[7], bit counter=0, -> SHIFT.
  - If tx_valid stays low, remain in LOAD indefinitely. SSEL stays 0 and SCK stays 0 (underrun stall, legal in mode 0).
  - tx_ready is high only in LOAD.
- SHIFT (each bit = 2*CLK_DIV cycles):
  - SCK low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - Synchronized MISO is sampled in the last cycle of the high phase and shifted into the receive register LSB.
  - On the falling edge (start of the next low phase) MOSI advances to the next bit.
  - MOSI is stable throughout every SCK high phase.
  - After the 8th high phase, SCK returns to 0:
    - rx_data <= assembled byte (first sampled bit = bit 7); rx_valid=1 for exactly one cycle.
    - Byte counter increments.
    - If byte counter == FRAME_BYTES -> HOLD, else -> LOAD.
- Minimum byte time with tx_valid held high: 16*CLK_DIV + 1 cycles (one LOAD cycle).
- HOLD:
  - SCK=0 for GAP_CYCLES cycles.
  - Then SSEL=1, busy=0, done=1 for one cycle, -> IDLE.
- start while busy is ignored (not queued). start in the done cycle is ignored; it is accepted from the following cycle.
- Byte counter width is clog2(FRAME_BYTES+1). Bit counter is 3 bits. The CLK_DIV counter reloads each half-period.
- No SCK edges ever occur while SSEL=1.
- Exactly 8*FRAME_BYTES rising SCK edges per frame.

Test Plan:
- Reset: rst_n=0 mid-idle -> SSEL=1, SCK=0, MOSI=0, busy=0, done=0, tx_ready=0, rx_valid=0 combinationally after rst_n falls.
- Frame (FRAME_BYTES=4, CLK_DIV=4):
  - Stimulus: tx 0xA5,0x3C,0xFF,0x00 with tx_valid held high; slave model drives MISO bytes 0x5A,0xC3,0x00,0xFF in mode 0.
  - Required: slave captures 0xA5,0x3C,0xFF,0x00; rx_valid fires 4 times with 0x5A,0xC3,0x00,0xFF; 32 SCK rising edges; one done pulse.
- Timing (CLK_DIV=4, GAP_CYCLES=2):
  - SCK high=4 and low=4 cycles.
  - SSEL low ≥2 cycles before first SCK rise and ≥2 after last SCK fall.
  - MOSI changes only while SCK=0.
  - Byte spacing is 65 cycles.
- Underrun: drop tx_valid for 20 cycles after byte 1 -> SCK held 0, SSEL held 0, tx_ready=1 throughout, no extra SCK edges; byte 2 is then sent correctly.
- Start handling:
  - Pulse start repeatedly during a frame -> only one frame runs.
  - start in the done cycle is ignored; start one cycle later launches a new frame (SSEL falls again).
- Reset mid-byte: assert rst_n=0 during bit 3 of byte 2 -> SSEL=1 and SCK=0 immediately, no rx_valid or done; the next full frame after release is bit-exact.

Source files
------------

// File: rtl/spi_frame_master_if.sv
// Host-side byte stream and frame control for spi_frame_master.
// The master modport is the host/bench side, the slave modport the SPI master core.
interface spi_frame_master_if;
  logic       start;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       done;

  modport master (
    output start, tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid, busy, done
  );

  modport slave (
    input  start, tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid, busy, done
  );
endinterface

// File: rtl/spi_frame_master.sv
// Mode-0, MSB-first SPI master: one SSEL-low frame of FRAME_BYTES bytes per start request,
// full-duplex, with each received byte returned on a one-cycle strobe.
module spi_frame_master #(
  parameter int unsigned FRAME_BYTES = 64,
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned GAP_CYCLES  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  spi_frame_master_if.slave    bus,
  output logic                 SCK,
  output logic                 MOSI,
  input  logic                 MISO,
  output logic                 SSEL
);

  localparam int unsigned CntMax = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax);
  localparam int unsigned BcW    = $clog2(FRAME_BYTES + 1);

  typedef enum logic [2:0] {StIdle, StSetup, StLoad, StShift, StHold} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [BcW-1:0]   byte_q, byte_d;
  logic [BcW-1:0]   byte_inc;
  logic [6:0]       tx_sh_q, tx_sh_d;
  logic [6:0]       rx_sh_q, rx_sh_d;
  logic [7:0]       rx_byte;
  logic             sck_q, sck_d;
  logic             mosi_q, mosi_d;
  logic             ssel_q, ssel_d;
  logic             tx_ready_q, tx_ready_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             miso_meta_q, miso_sync_q;

  assign byte_inc = byte_q + BcW'(1);
  // Byte as it stands once the current sample is shifted in; first sample ends up in bit 7.
  assign rx_byte  = {rx_sh_q, miso_sync_q};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    ssel_d     = ssel_q;
    tx_ready_d = tx_ready_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A start coinciding with the done pulse is dropped, not queued.
        if (bus.start && !done_q) begin
          state_d = StSetup;
          ssel_d  = 1'b0;
          busy_d  = 1'b1;
          byte_d  = '0;
          cnt_d   = '0;
        end
      end
      StSetup: begin
        if (cnt_q == CntW'(GAP_CYCLES - 1)) begin
          state_d    = StLoad;
          tx_ready_d = 1'b1;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StLoad: begin
        if (bus.tx_valid && tx_ready_q) begin
          tx_sh_d    = bus.tx_data[6:0];
          mosi_d     = bus.tx_data[7];
          bit_d      = '0;
          cnt_d      = '0;
          tx_ready_d = 1'b0;
          state_d    = StShift;
        end
      end
      StShift: begin
        if (cnt_q != CntW'(CLK_DIV - 1)) begin
          cnt_d = cnt_q + CntW'(1);
        end else begin
          cnt_d = '0;
          if (!sck_q) begin
            sck_d = 1'b1;
          end else begin
            sck_d   = 1'b0;
            rx_sh_d = rx_byte[6:0];
            if (bit_q == 3'd7) begin
              rx_data_d  = rx_byte;
              rx_valid_d = 1'b1;
              byte_d     = byte_inc;
              if (byte_inc == BcW'(FRAME_BYTES)) begin
                state_d = StHold;
              end else begin
                state_d    = StLoad;
                tx_ready_d = 1'b1;
              end
            end else begin
              bit_d   = bit_q + 3'd1;
              mosi_d  = tx_sh_q[6];
              tx_sh_d = {tx_sh_q[5:0], 1'b0};
            end
          end
        end
      end
      StHold: begin
        if (cnt_q == CntW'(GAP_CYCLES - 1)) begin
          state_d = StIdle;
          ssel_d  = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_q       <= '0;
      byte_q      <= '0;
      tx_sh_q     <= '0;
      rx_sh_q     <= '0;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
      ssel_q      <= 1'b1;
      tx_ready_q  <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      miso_meta_q <= 1'b0;
      miso_sync_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      byte_q      <= byte_d;
      tx_sh_q     <= tx_sh_d;
      rx_sh_q     <= rx_sh_d;
      sck_q       <= sck_d;
      mosi_q      <= mosi_d;
      ssel_q      <= ssel_d;
      tx_ready_q  <= tx_ready_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      miso_meta_q <= MISO;
      miso_sync_q <= miso_meta_q;
    end
  end

  assign SCK          = sck_q;
  assign MOSI         = mosi_q;
  assign SSEL         = ssel_q;
  assign bus.tx_ready = tx_ready_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_spi_frame_master.sv
// Directed bench for spi_frame_master: mode-0 slave model, pin-level timing monitor,
// and a linear sequence of frames covering reset, underrun, start handling and abort.
module tb_spi_frame_master;
  localparam int FB = 4;
  localparam int CD = 4;
  localparam int GC = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic SCK, MOSI, MISO, SSEL;

  spi_frame_master_if bus ();

  spi_frame_master #(
    .FRAME_BYTES(FB),
    .CLK_DIV    (CD),
    .GAP_CYCLES (GC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus),
    .SCK  (SCK),
    .MOSI (MOSI),
    .MISO (MISO),
    .SSEL (SSEL)
  );

  always #5 clk = ~clk;

  logic [7:0] tx_mem   [FB] = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
  logic [7:0] resp_mem [FB] = '{8'h5A, 8'hC3, 8'h00, 8'hFF};

  int n_checks = 0;
  int n_fail   = 0;

  // Byte source: index advances on every accepted handshake, rebased per frame.
  int         tx_cnt  = 0;
  int         tx_base = 0;
  logic [1:0] tx_idx;
  always @(posedge clk) if (bus.tx_valid && bus.tx_ready) tx_cnt <= tx_cnt + 1;
  assign tx_idx      = 2'(tx_cnt - tx_base);
  assign bus.tx_data = tx_mem[tx_idx];

  // Mode-0 slave: capture MOSI on SCK rise, present next MISO bit on SSEL/SCK fall.
  int         sl_k = 0;
  logic [7:0] sl_sh = '0;
  logic [7:0] sl_rb;
  logic [7:0] cap [FB];
  logic       miso_r = 1'b0;
  logic       sl_ssel_p = 1'b1;
  logic       sl_sck_p  = 1'b0;
  assign MISO = miso_r;

  always @(SSEL or SCK) begin
    if (!SSEL && sl_ssel_p) begin
      sl_k   = 0;
      sl_rb  = resp_mem[0];
      miso_r = sl_rb[7];
    end else if (!SSEL && SCK && !sl_sck_p) begin
      sl_sh = {sl_sh[6:0], MOSI};
      sl_k++;
      if (sl_k % 8 == 0 && sl_k <= 8 * FB) cap[2'((sl_k / 8) - 1)] = sl_sh;
    end else if (!SSEL && !SCK && sl_sck_p && sl_k < 8 * FB) begin
      sl_rb  = resp_mem[2'(sl_k / 8)];
      miso_r = sl_rb[3'(7 - (sl_k % 8))];
    end
    sl_ssel_p = SSEL;
    sl_sck_p  = SCK;
  end

  // Pin monitor, sampled on the inactive clock edge.
  int cyc = 0, rises = 0, dones = 0, ssel_falls = 0;
  int sck_in_idle = 0, mosi_bad = 0, hi_bad = 0, lo4 = 0, lo5 = 0, lo_short = 0;
  int setup_bad = 0, hold_bad = 0;
  int hi_run = 0, lo_run = 0, hold_run = 0, setup_len = 0;
  logic seen_rise = 1'b0;
  logic sck_p = 1'b0, mosi_p = 1'b0, ssel_p = 1'b1;
  int         rx_n = 0;
  logic [7:0] rx_log [64];
  int         rx_cyc [64];

  always @(negedge clk) begin
    cyc++;
    if (bus.done) dones++;
    if (bus.rx_valid && rx_n < 64) begin
      rx_log[rx_n] = bus.rx_data;
      rx_cyc[rx_n] = cyc;
      rx_n++;
    end
    if (SCK && SSEL) sck_in_idle++;
    if (!rst_n) begin
      hi_run    = 0;
      lo_run    = 0;
      seen_rise = 1'b0;
    end else begin
      if (!SSEL && ssel_p) begin
        ssel_falls++;
        seen_rise = 1'b0;
        setup_len = 0;
      end
      if (SSEL && !ssel_p && hold_run < GC) hold_bad++;
      if (MOSI !== mosi_p && SCK) mosi_bad++;
      if (SCK && !sck_p) begin
        rises++;
        if (seen_rise) begin
          if (lo_run == CD) lo4++;
          else if (lo_run == CD + 1) lo5++;
          else if (lo_run < CD) lo_short++;
        end else if (setup_len < GC) begin
          setup_bad++;
        end
        seen_rise = 1'b1;
      end
      if (!SCK && sck_p) begin
        if (hi_run != CD) hi_bad++;
        hold_run = 0;
      end
      hi_run = SCK ? hi_run + 1 : 0;
      lo_run = (!SCK && !SSEL) ? lo_run + 1 : 0;
      if (!SCK && !SSEL) hold_run++;
      if (!SSEL && !seen_rise) setup_len++;
    end
    sck_p  = SCK;
    mosi_p = MOSI;
    ssel_p = SSEL;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic int cur(input int which);
    case (which)
      0:       return rises;
      1:       return tx_cnt - tx_base;
      default: return rx_n;
    endcase
  endfunction

  task automatic wait_ge(input int which, input int target, input string tag);
    int n = 0;
    while (cur(which) < target && n < 2000) begin
      tick();
      n++;
    end
    chk(tag, 32'(cur(which) >= target), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (bus.done !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    chk({tag, " done pulse"}, 32'(bus.done), 32'd1);
  endtask

  int rx0, rise0, done0, fall0;

  task automatic snap();
    rx0     = rx_n;
    rise0   = rises;
    done0   = dones;
    fall0   = ssel_falls;
    tx_base = tx_cnt;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic check_frame(input string tag);
    for (int i = 0; i < FB; i++) begin
      chk($sformatf("%s slave byte %0d", tag, i), 32'(cap[i]), 32'(tx_mem[i]));
      chk($sformatf("%s rx byte %0d", tag, i), 32'(rx_log[rx0 + i]), 32'(resp_mem[i]));
    end
    chk({tag, " rx_valid count"}, rx_n - rx0, FB);
    chk({tag, " sck rises"}, rises - rise0, 8 * FB);
    chk({tag, " done count"}, dones - done0, 1);
    chk({tag, " frame count"}, ssel_falls - fall0, 1);
  endtask

  initial begin
    int hb0, lb4, lb5, ls0, mb0, sb0, hd0, stall_bad, r_before;
    bus.start    = 1'b0;
    bus.tx_valid = 1'b0;

    // Reset
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    chk("reset SSEL", 32'(SSEL), 32'd1);
    chk("reset SCK", 32'(SCK), 32'd0);
    chk("reset MOSI", 32'(MOSI), 32'd0);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset tx_ready", 32'(bus.tx_ready), 32'd0);
    chk("reset rx_valid", 32'(bus.rx_valid), 32'd0);
    chk("reset rx_data", 32'(bus.rx_data), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // Frame 1: streaming with tx_valid held high, plus pin timing
    snap();
    hb0 = hi_bad; lb4 = lo4; lb5 = lo5; ls0 = lo_short;
    mb0 = mosi_bad; sb0 = setup_bad; hd0 = hold_bad;
    bus.tx_valid = 1'b1;
    pulse_start();
    chk("f1 SSEL low after start", 32'(SSEL), 32'd0);
    chk("f1 busy after start", 32'(bus.busy), 32'd1);
    wait_done("f1");
    check_frame("f1");
    for (int i = 0; i < FB - 1; i++)
      chk($sformatf("f1 byte spacing %0d", i), rx_cyc[rx0 + i + 1] - rx_cyc[rx0 + i], 65);
    chk("f1 high phase length errors", hi_bad - hb0, 0);
    chk("f1 low phases of 4", lo4 - lb4, 28);
    chk("f1 low phases of 5", lo5 - lb5, 3);
    chk("f1 short low phases", lo_short - ls0, 0);
    chk("f1 MOSI change while SCK high", mosi_bad - mb0, 0);
    chk("f1 SSEL setup too short", setup_bad - sb0, 0);
    chk("f1 SSEL hold too short", hold_bad - hd0, 0);
    tick();
    chk("f1 busy after done", 32'(bus.busy), 32'd0);
    chk("f1 SSEL after done", 32'(SSEL), 32'd1);
    repeat (5) tick();

    // Frame 2: underrun after byte 1
    snap();
    bus.tx_valid = 1'b1;
    pulse_start();
    wait_ge(1, 1, "f2 byte 1 accepted");
    bus.tx_valid = 1'b0;
    wait_ge(2, rx0 + 1, "f2 byte 1 received");
    stall_bad = 0;
    r_before  = rises;
    for (int i = 0; i < 20; i++) begin
      if (SCK !== 1'b0 || SSEL !== 1'b0 || bus.tx_ready !== 1'b1) stall_bad++;
      tick();
    end
    chk("f2 stall pin violations", stall_bad, 0);
    chk("f2 sck edges during stall", rises - r_before, 0);
    bus.tx_valid = 1'b1;
    wait_done("f2");
    check_frame("f2");
    repeat (5) tick();

    // Frame 3: repeated start during a frame, then start in the done cycle
    snap();
    pulse_start();
    for (int k = 0; k < 5; k++) begin
      repeat (40) tick();
      pulse_start();
    end
    wait_done("f3");
    check_frame("f3");
    bus.start = 1'b1;
    tick();
    chk("start in done cycle ignored SSEL", 32'(SSEL), 32'd1);
    chk("start in done cycle ignored busy", 32'(bus.busy), 32'd0);
    snap();
    tick();
    bus.start = 1'b0;
    chk("start after done accepted SSEL", 32'(SSEL), 32'd0);
    chk("start after done accepted busy", 32'(bus.busy), 32'd1);
    wait_done("f4");
    check_frame("f4");
    repeat (5) tick();

    // Frame 5: reset during byte 2, then a clean frame
    snap();
    pulse_start();
    wait_ge(0, rise0 + 11, "f5 reach byte 2");
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort SSEL", 32'(SSEL), 32'd1);
    chk("abort SCK", 32'(SCK), 32'd0);
    chk("abort busy", 32'(bus.busy), 32'd0);
    chk("abort tx_ready", 32'(bus.tx_ready), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("abort rx_valid count", rx_n - rx0, 1);
    chk("abort done count", dones - done0, 0);
    snap();
    pulse_start();
    wait_done("f6");
    check_frame("f6");
    bus.tx_valid = 1'b0;
    repeat (3) tick();
    chk("sck while SSEL high", sck_in_idle, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
